// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: synchronous first-word-fall-through byte FIFO feeding i2c_slave.
// The head byte is always presented on fifo_dout, and fifo_rd_en acknowledges it.
// Occupancy is held in its own register, and all status outputs decode from it.
module i2c_tx_fifo #(
   parameter int DEPTH     = 16,
   parameter int DATA_W    = 8,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     fifo_valid,
   output logic [DATA_W-1:0]        fifo_dout,
   input  logic                     fifo_rd_en,
   input  logic                     flush,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic              pop;
   logic              push;
   logic              ovf_evt;
   logic              unf_evt;

   // Status outputs are plain decodes of the count register.
   assign full         = (count == CW'(DEPTH));
   assign almost_empty = (count <= CW'(AE_THRESH));
   assign fifo_valid   = (count != '0);
   assign fifo_dout    = fifo_valid ? mem[rd_ptr] : '0;

   // A pop needs a valid head. A push into a full FIFO is allowed only when
   // the head leaves in the same cycle. flush suppresses both operations and
   // both error events.
   assign pop     = fifo_rd_en && fifo_valid && !flush;
   assign push    = wr_en && (!full || (fifo_rd_en && fifo_valid)) && !flush;
   assign ovf_evt = wr_en && full && !fifo_rd_en && !flush;
   assign unf_evt = fifo_rd_en && !fifo_valid && !flush;

   // Storage write. The memory has no reset and only its contents at pushed
   // slots are ever observed.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy. flush returns to empty without touching flags.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Sticky error flags. A new event in the clr_err cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (unf_evt)      underflow <= 1'b1;
         else if (clr_err) underflow <= 1'b0;
      end
   end

endmodule
